// File: rtl/cpu_oci_arb_pkg.sv
// Shared types for the OCI debug port arbiter.
// Command bundle, owner tags and FSM state encodings.
package cpu_oci_arb_pkg;

    localparam int OCI_ADDR_W = 8;
    localparam int OCI_DATA_W = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RD   = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        RD   = ST_RD
    } state_e;

    typedef enum logic {
        OWN_JTAG = 1'b0,
        OWN_AV   = 1'b1
    } owner_e;

    typedef struct packed {
        logic                  wr;
        logic [OCI_ADDR_W-1:0] addr;
        logic [OCI_DATA_W-1:0] wdata;
    } oci_cmd_t;

endpackage

// File: rtl/cpu_oci_cmd_fifo.sv
// Small synchronous FIFO buffering JTAG debug commands.
// A full FIFO still accepts a push when a pop happens in the same cycle.
module cpu_oci_cmd_fifo
    import cpu_oci_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  logic     pop,
    input  oci_cmd_t din,
    output logic     full,
    output logic     empty,
    output oci_cmd_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    oci_cmd_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cpu_oci_debug_arbiter.sv
// Arbitrates the OCI debug memory port between buffered JTAG
// commands and a back-pressured Avalon-MM debug slave.
module cpu_oci_debug_arbiter
    import cpu_oci_arb_pkg::*;
#(
    parameter int ADDR_W      = OCI_ADDR_W,
    parameter int DATA_W      = OCI_DATA_W,
    parameter int JFIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jtag_cmd_valid,
    input  logic              jtag_cmd_wr,
    input  logic [ADDR_W-1:0] jtag_cmd_addr,
    input  logic [DATA_W-1:0] jtag_cmd_wdata,
    output logic [DATA_W-1:0] mon_dreg,
    output logic              mon_ready,
    output logic              jtag_overflow,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [ADDR_W-1:0] av_address,
    input  logic [DATA_W-1:0] av_writedata,
    output logic              av_waitrequest,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_readdatavalid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    oci_cmd_t   jcmd_in;
    oci_cmd_t   jhead;
    logic       fifo_full;
    logic       fifo_empty;
    logic [0:0] state;
    owner_e     last_grant;
    owner_e     rd_owner;
    logic       idle;
    logic       av_req;
    logic       grant_j;
    logic       grant_a;
    logic       grant;
    logic       grant_rd;
    logic       rd_av;
    logic       rd_jtag;

    assign jcmd_in = '{
        wr:    jtag_cmd_wr,
        addr:  OCI_ADDR_W'(jtag_cmd_addr),
        wdata: OCI_DATA_W'(jtag_cmd_wdata)
    };

    cpu_oci_cmd_fifo #(
        .DEPTH (JFIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (jtag_cmd_valid),
        .pop     (grant_j),
        .din     (jcmd_in),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (jhead)
    );

    // Grants are masked while reset is asserted so the port stays quiet.
    assign idle    = reset_n & (state == ST_IDLE);
    assign av_req  = av_read | av_write;
    assign grant_j = idle & ~fifo_empty &
                     (~av_req | (last_grant == OWN_AV));
    assign grant_a = idle & ~grant_j & av_req;
    assign grant   = grant_j | grant_a;

    always_comb begin
        mem_req   = grant;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            grant_j: begin
                mem_we    = jhead.wr;
                mem_addr  = ADDR_W'(jhead.addr);
                mem_wdata = DATA_W'(jhead.wdata);
            end
            grant_a: begin
                mem_we    = av_write;
                mem_addr  = av_address;
                mem_wdata = av_writedata;
            end
            default: ;
        endcase
    end

    assign grant_rd = grant & ~mem_we;

    assign rd_av   = reset_n & (state == ST_RD) & (rd_owner == OWN_AV);
    assign rd_jtag = (state == ST_RD) & (rd_owner == OWN_JTAG);

    assign av_waitrequest   = ~grant_a;
    assign av_readdatavalid = rd_av;
    assign av_readdata      = rd_av ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            last_grant    <= OWN_AV;
            rd_owner      <= OWN_AV;
            jtag_overflow <= 1'b0;
            mon_dreg      <= '0;
            mon_ready     <= 1'b0;
        end else begin
            if (grant) last_grant <= grant_j ? OWN_JTAG : OWN_AV;

            if (state == ST_RD) begin
                state <= ST_IDLE;
            end else if (grant_rd) begin
                state    <= ST_RD;
                rd_owner <= grant_j ? OWN_JTAG : OWN_AV;
            end

            if (jtag_cmd_valid & fifo_full & ~grant_j)
                jtag_overflow <= 1'b1;

            // Returning read data beats a same-cycle clear.
            if (rd_jtag) begin
                mon_dreg  <= mem_rdata;
                mon_ready <= 1'b1;
            end else if (jtag_cmd_valid) begin
                mon_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_oci_debug_arbiter.sv
// Randomized bench for cpu_oci_debug_arbiter against a
// queue-based transaction model of the shared debug port.
module tb_cpu_oci_debug_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        jtag_cmd_valid;
    logic        jtag_cmd_wr;
    logic [7:0]  jtag_cmd_addr;
    logic [31:0] jtag_cmd_wdata;
    logic [31:0] mon_dreg;
    logic        mon_ready;
    logic        jtag_overflow;
    logic        av_read;
    logic        av_write;
    logic [7:0]  av_address;
    logic [31:0] av_writedata;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    cpu_oci_debug_arbiter #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .JFIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .jtag_cmd_valid   (jtag_cmd_valid),
        .jtag_cmd_wr      (jtag_cmd_wr),
        .jtag_cmd_addr    (jtag_cmd_addr),
        .jtag_cmd_wdata   (jtag_cmd_wdata),
        .mon_dreg         (mon_dreg),
        .mon_ready        (mon_ready),
        .jtag_overflow    (jtag_overflow),
        .av_read          (av_read),
        .av_write         (av_write),
        .av_address       (av_address),
        .av_writedata     (av_writedata),
        .av_waitrequest   (av_waitrequest),
        .av_readdata      (av_readdata),
        .av_readdatavalid (av_readdatavalid),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    function automatic logic [31:0] init_word(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, 8'hA5, ~a, 8'h3C};
    endfunction

    // Debug RAM behind the shared port: one-cycle read latency.
    logic [31:0] ram [256];
    bit [255:0]  ram_written;
    always @(posedge clk) begin
        if (mem_req && !mem_we)
            mem_rdata <= ram_written[mem_addr] ? ram[mem_addr]
                                               : init_word(mem_addr);
        if (mem_req && mem_we) begin
            ram[mem_addr]         <= mem_wdata;
            ram_written[mem_addr] <= 1'b1;
        end
    end

    typedef struct {
        bit       wr;
        bit [7:0] addr;
        bit [31:0] wdata;
    } cmd_t;

    cmd_t      q[$];
    bit [31:0] shadow [256];
    int        pend;
    bit [7:0]  pend_addr;
    bit        last_av;
    bit        m_ovf;
    bit        m_rdy;
    bit [31:0] m_dreg;
    int        n_chk;
    int        n_fail;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_in();
        jtag_cmd_valid = 1'b0;
        jtag_cmd_wr    = 1'b0;
        jtag_cmd_addr  = 8'h0;
        jtag_cmd_wdata = 32'h0;
        av_read        = 1'b0;
        av_write       = 1'b0;
        av_address     = 8'h0;
        av_writedata   = 32'h0;
    endtask

    // Called #1 after a rising edge with inputs already driven.
    task automatic step();
        bit        avreq;
        bit        jwin;
        bit        awin;
        bit        e_req;
        bit        e_we;
        bit        e_rdv;
        bit [7:0]  e_addr;
        bit [31:0] e_wd;
        e_req = 0; e_we = 0; e_addr = 0; e_wd = 0;
        jwin = 0; awin = 0;
        avreq = av_read | av_write;
        if (reset_n && pend == 0) begin
            jwin = (q.size() > 0) && (!avreq || last_av);
            awin = !jwin && avreq;
            if (jwin) begin
                e_req = 1; e_we = q[0].wr;
                e_addr = q[0].addr; e_wd = q[0].wdata;
            end else if (awin) begin
                e_req = 1; e_we = av_write;
                e_addr = av_address; e_wd = av_writedata;
            end
        end
        e_rdv = reset_n && pend == 1;
        #4;
        chk("mem_req", mem_req, e_req);
        if (e_req) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, e_wd);
        end
        chk("waitrequest", av_waitrequest, !awin);
        chk("rdvalid", av_readdatavalid, e_rdv);
        if (e_rdv) chk("readdata", av_readdata, shadow[pend_addr]);
        chk("mon_ready", mon_ready, m_rdy);
        chk("mon_dreg", mon_dreg, m_dreg);
        chk("overflow", jtag_overflow, m_ovf);
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
            pend = 0; last_av = 1; m_ovf = 0; m_rdy = 0; m_dreg = 0;
        end else begin
            if (pend == 2) begin
                m_dreg = shadow[pend_addr];
                m_rdy  = 1;
            end else if (jtag_cmd_valid) begin
                m_rdy = 0;
            end
            pend = 0;
            if (jwin || awin) begin
                last_av = awin;
                if (e_we) shadow[e_addr] = e_wd;
                else begin
                    pend      = awin ? 1 : 2;
                    pend_addr = e_addr;
                end
            end
            if (jwin) void'(q.pop_front());
            if (jtag_cmd_valid) begin
                if (q.size() >= 2) m_ovf = 1;
                else q.push_back('{jtag_cmd_wr, jtag_cmd_addr, jtag_cmd_wdata});
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic jpulse(input bit wr, input bit [7:0] a, input bit [31:0] d);
        jtag_cmd_valid = 1'b1;
        jtag_cmd_wr    = wr;
        jtag_cmd_addr  = a;
        jtag_cmd_wdata = d;
    endtask

    task automatic rand_in(input int pj, input int pa);
        jtag_cmd_valid = ($urandom_range(99) < pj);
        jtag_cmd_wr    = 1'($urandom_range(1));
        jtag_cmd_addr  = 8'($urandom_range(15));
        jtag_cmd_wdata = $urandom;
        av_read        = ($urandom_range(99) < pa);
        av_write       = ($urandom_range(99) < pa / 2);
        av_address     = 8'($urandom_range(15));
        av_writedata   = $urandom;
        reset_n        = ($urandom_range(299) != 0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        pend = 0; last_av = 1; m_ovf = 0; m_rdy = 0; m_dreg = 0;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(8'(i));
        idle_in();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // JTAG read of 0x10
        jpulse(1'b0, 8'h10, 32'h0);
        step();
        idle_in();
        for (int i = 0; i < 4; i++) step();
        chk("t1_dreg", mon_dreg, 32'hDEADBEEF);
        chk("t1_ready", mon_ready, 1'b1);

        // Avalon write with JTAG idle
        do_reset();
        av_write = 1'b1; av_address = 8'h05; av_writedata = 32'h1234;
        step();
        idle_in();
        step();
        chk("t2_ram", ram[8'h05], 32'h1234);

        // continuous Avalon reads plus spaced JTAG reads
        do_reset();
        for (int i = 0; i < 16; i++) begin
            av_read = 1'b1; av_address = 8'(i);
            if (i % 3 == 0 && i < 12) jpulse(1'b0, 8'(8'h20 + i), 32'h0);
            else jtag_cmd_valid = 1'b0;
            step();
        end
        idle_in();
        step();
        chk("t3_ovf", jtag_overflow, 1'b0);

        // three pulses while Avalon holds the port
        do_reset();
        jpulse(1'b1, 8'h30, 32'hCAFE0001);
        step();
        av_read = 1'b1; av_address = 8'h01;
        jpulse(1'b0, 8'h30, 32'h0);
        step();
        jpulse(1'b0, 8'h31, 32'h0);
        step();
        jpulse(1'b0, 8'h32, 32'h0);
        step();
        jtag_cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        idle_in();
        step();
        chk("t4_ovf", jtag_overflow, 1'b1);

        // reset during the read-data cycle of an Avalon read
        do_reset();
        av_read = 1'b1; av_address = 8'h07;
        jpulse(1'b0, 8'h08, 32'h0);
        step();
        idle_in();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t5_wait", av_waitrequest, 1'b1);

        // read and write together act as a write
        do_reset();
        av_read = 1'b1; av_write = 1'b1;
        av_address = 8'h22; av_writedata = 32'h5A5A5A5A;
        step();
        idle_in();
        for (int i = 0; i < 2; i++) step();
        chk("t6_ram", ram[8'h22], 32'h5A5A5A5A);

        // random traffic at several densities
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 700; i++) begin
                rand_in(20 + ph * 30, 30 + ph * 30);
                step();
            end
        end
        idle_in();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
